// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch lap controller.
// Holds the FSM state enum, BCD width, the 9:59.9 ceiling and the
// button-pulse priority encoder (clear > start_stop > lap).
package stopwatch_pkg;

    localparam int BCD_W = 16;

    // 9:59.9 -- last displayable time; the counter is held here rather than wrapping
    localparam logic [BCD_W-1:0] MAX_BCD = 16'h9599;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RUN      = 3'd1,
        ST_LAP_HOLD = 3'd2,
        ST_PAUSE    = 3'd3,
        ST_DONE     = 3'd4,
        ST_CLEAR    = 3'd5
    } state_t;

    // Only one button pulse is acted on per cycle; the others are dropped.
    typedef enum logic [1:0] {
        PULSE_NONE       = 2'd0,
        PULSE_LAP        = 2'd1,
        PULSE_START_STOP = 2'd2,
        PULSE_CLEAR      = 2'd3
    } pulse_t;

    function automatic pulse_t pulse_select(input logic clear,
                                            input logic start_stop,
                                            input logic lap);
        pulse_t p;
        p = PULSE_NONE;
        if (clear)
            p = PULSE_CLEAR;
        else if (start_stop)
            p = PULSE_START_STOP;
        else if (lap)
            p = PULSE_LAP;
        return p;
    endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_lap_buffer.sv
// lap_buffer: LAP_DEPTH x BCD_W circular register file for captured laps.
// The write pointer wraps, the count saturates at LAP_DEPTH so the oldest
// entry is overwritten once full. Read port is asynchronous.
module lap_buffer
    import stopwatch_pkg::*;
#(
    parameter  int LAP_DEPTH = 4,
    localparam int IW        = $clog2(LAP_DEPTH),
    localparam int CW        = IW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [BCD_W-1:0] wr_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [BCD_W-1:0] rd_data,
    output logic [IW-1:0]    wr_ptr,
    output logic [CW-1:0]    count
);

    logic [BCD_W-1:0] mem [LAP_DEPTH];

    // Write side: store entry, advance pointer, saturate count; clr only empties the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < LAP_DEPTH; i++)
                mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + IW'(1);
            if (count != CW'(LAP_DEPTH))
                count <= count + CW'(1);
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// stopwatch_lap_ctrl: sequences the m:ss.t BCD counter, captures laps and
// selects live time or a held lap for the display scanner.
// Optional lap recall while paused: define STOPWATCH_LAP_RECALL_EN.
//
// state       | meaning
// ST_IDLE     | counter cleared, waiting for start
// ST_RUN      | counting, display shows live time
// ST_LAP_HOLD | counting, display shows last lap for HOLD_TICKS ticks
// ST_PAUSE    | counting stopped, may resume or clear (or recall laps)
// ST_DONE     | counter reached 9:59.9, only clear leaves
// ST_CLEAR    | single cycle: clear counter and lap buffer
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter  int LAP_DEPTH  = 4,
    parameter  int HOLD_TICKS = 20,
    localparam int IW         = $clog2(LAP_DEPTH),
    localparam int CW         = IW + 1,
    localparam int HW         = $clog2(HOLD_TICKS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start_stop,
    input  logic             lap,
    input  logic             clear,
    input  logic [BCD_W-1:0] time_bcd,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic [BCD_W-1:0] disp_bcd,
    output logic             lap_active,
    output logic [CW-1:0]    lap_count,
    output logic [IW-1:0]    lap_idx,
    output logic             busy
);

    state_t           state_q;
    state_t           state_nx;
    pulse_t           pulse;
    logic             at_max;
    logic             hold_done;
    logic             lap_wr;
    logic             hold_load;
    logic             buf_clr;
    logic [HW-1:0]    hold_cnt;
    logic [BCD_W-1:0] lap_latch;
    logic [BCD_W-1:0] lap_src;
    logic [BCD_W-1:0] rd_data;
    logic [IW-1:0]    wr_ptr;
`ifdef STOPWATCH_LAP_RECALL_EN
    logic             recall_q;
    logic             recall_step;
    logic [IW-1:0]    newest_idx;
    logic [IW-1:0]    prev_idx;
`endif

    assign pulse     = pulse_select(clear, start_stop, lap);
    assign at_max    = (time_bcd == MAX_BCD);
    assign hold_done = tick && (hold_cnt == HW'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_nx;
    end

    // Next-state and one-cycle control strobes
    always_comb begin
        state_nx  = state_q;
        lap_wr    = 1'b0;
        hold_load = 1'b0;
        buf_clr   = 1'b0;
`ifdef STOPWATCH_LAP_RECALL_EN
        recall_step = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pulse == PULSE_START_STOP)
                    state_nx = ST_RUN;
            end
            ST_RUN, ST_LAP_HOLD: begin
                if (at_max) begin
                    state_nx = ST_DONE;
                end else if (pulse == PULSE_START_STOP) begin
                    state_nx = ST_PAUSE;
                end else if (pulse == PULSE_LAP) begin
                    lap_wr    = 1'b1;
                    hold_load = 1'b1;
                    state_nx  = ST_LAP_HOLD;
                end else if (state_q == ST_LAP_HOLD && hold_done) begin
                    state_nx = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (pulse == PULSE_CLEAR)
                    state_nx = ST_CLEAR;
                else if (pulse == PULSE_START_STOP)
                    state_nx = ST_RUN;
`ifdef STOPWATCH_LAP_RECALL_EN
                else if (pulse == PULSE_LAP && lap_count != '0)
                    recall_step = 1'b1;
`endif
            end
            ST_DONE: begin
                if (pulse == PULSE_CLEAR)
                    state_nx = ST_CLEAR;
            end
            ST_CLEAR: begin
                buf_clr  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Hold timer: reloaded on every capture, counts ticks down while the lap is shown
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            hold_cnt <= '0;
        else if (hold_load)
            hold_cnt <= HW'(HOLD_TICKS);
        else if (state_nx != ST_LAP_HOLD)
            hold_cnt <= '0;
        else if (tick)
            hold_cnt <= hold_cnt - HW'(1);
    end

    // Lap latch and displayed buffer index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lap_latch <= '0;
            lap_idx   <= '0;
        end else begin
            if (lap_wr)
                lap_latch <= time_bcd;
            if (buf_clr)
                lap_idx <= '0;
            else if (lap_wr)
                lap_idx <= wr_ptr;
`ifdef STOPWATCH_LAP_RECALL_EN
            else if (recall_step)
                lap_idx <= recall_q ? prev_idx : newest_idx;
`endif
        end
    end

`ifdef STOPWATCH_LAP_RECALL_EN
    // Recall mode: entered by the first lap pulse in PAUSE, dropped when PAUSE is left
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            recall_q <= 1'b0;
        else
            recall_q <= (state_nx == ST_PAUSE) && (recall_q || recall_step);
    end

    // First recall pulse jumps to the newest entry; later ones step back through valid laps
    assign newest_idx = wr_ptr - IW'(1);
    assign prev_idx   = (lap_idx == '0) ? IW'(lap_count - CW'(1)) : lap_idx - IW'(1);
    assign lap_src    = recall_q ? rd_data : lap_latch;
    assign lap_active = (state_q == ST_LAP_HOLD) || recall_q;
`else
    logic unused_rd;
    assign unused_rd  = ^rd_data;
    assign lap_src    = lap_latch;
    assign lap_active = (state_q == ST_LAP_HOLD);
`endif

    assign busy     = (state_q == ST_RUN) || (state_q == ST_LAP_HOLD);
    assign cnt_en   = busy && !at_max;
    assign cnt_clr  = (state_q == ST_CLEAR);
    assign disp_bcd = lap_active ? lap_src : time_bcd;

    lap_buffer #(
        .LAP_DEPTH (LAP_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (lap_wr),
        .wr_data (time_bcd),
        .rd_idx  (lap_idx),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr),
        .count   (lap_count)
    );

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb_stopwatch_lap_ctrl: randomized and directed checks of stopwatch_lap_ctrl
// against a behavioural stopwatch model. The bench also plays the role of the
// BCD counter (time kept as integer tenths of a second).
// Build with STOPWATCH_LAP_RECALL_EN to exercise lap recall.
module tb_stopwatch_lap_ctrl;

    localparam int D       = 4;
    localparam int HOLD    = 20;
    localparam int T_MAX   = 5999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] time_bcd = 16'h0000;
    logic        cnt_en;
    logic        cnt_clr;
    logic [15:0] disp_bcd;
    logic        lap_active;
    logic [2:0]  lap_count;
    logic [1:0]  lap_idx;
    logic        busy;
    logic [24:0] obs;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model
    bit          m_idle, m_run, m_pause, m_done, m_clr, m_recall;
    int          m_hold, m_total, m_idx, m_k, m_tenths;
    logic [15:0] m_latch;
    logic [15:0] m_mem [D];

    stopwatch_lap_ctrl #(.LAP_DEPTH(D), .HOLD_TICKS(HOLD)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .time_bcd   (time_bcd),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .disp_bcd   (disp_bcd),
        .lap_active (lap_active),
        .lap_count  (lap_count),
        .lap_idx    (lap_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign obs = {cnt_en, cnt_clr, busy, lap_active, disp_bcd, lap_count, lap_idx};

    function automatic logic [15:0] to_bcd(input int t);
        int s;
        s = t / 10;
        return {4'(s / 60), 4'((s % 60) / 10), 4'(s % 10), 4'(t % 10)};
    endfunction

    function automatic int n_laps();
        return (m_total < D) ? m_total : D;
    endfunction

    function automatic logic [24:0] exp_vec();
        logic [15:0] d;
        bit          act;
        int          c;
        c   = n_laps();
        act = (m_run && m_hold > 0) || m_recall;
        if (m_recall)
            d = m_mem[m_idx];
        else if (act)
            d = m_latch;
        else
            d = to_bcd(m_tenths);
        return {(m_run && m_tenths != T_MAX), m_clr, m_run, act, d, 3'(c), 2'(m_idx)};
    endfunction

    task automatic model_reset();
        m_idle = 1; m_run = 0; m_pause = 0; m_done = 0; m_clr = 0; m_recall = 0;
        m_hold = 0; m_total = 0; m_idx = 0; m_k = 0; m_latch = 16'h0000;
        for (int i = 0; i < D; i++) m_mem[i] = 16'h0000;
    endtask

    // one clock edge of the stopwatch as a user would describe it
    task automatic model_edge(input logic ss, input logic lp, input logic cl, input logic tk);
        bit at_max, s_w, l_w, c_w;
        int t0;
        t0     = m_tenths;
        at_max = (t0 == T_MAX);
        c_w    = cl;
        s_w    = !cl && ss;
        l_w    = !cl && !ss && lp;
        if (m_run && !at_max && tk) m_tenths = t0 + 1;
        if (m_clr) begin
            m_clr = 0; m_idle = 1; m_total = 0; m_idx = 0; m_tenths = 0;
        end else if (m_idle) begin
            if (s_w) begin m_idle = 0; m_run = 1; end
        end else if (m_run) begin
            if (at_max) begin
                m_run = 0; m_done = 1; m_hold = 0;
            end else if (s_w) begin
                m_run = 0; m_pause = 1; m_hold = 0;
            end else if (l_w) begin
                m_mem[m_total % D] = to_bcd(t0);
                m_idx   = m_total % D;
                m_total = m_total + 1;
                m_latch = to_bcd(t0);
                m_hold  = HOLD;
            end else if (m_hold > 0 && tk) begin
                m_hold = m_hold - 1;
            end
        end else if (m_pause) begin
            if (c_w) begin
                m_pause = 0; m_clr = 1; m_recall = 0;
            end else if (s_w) begin
                m_pause = 0; m_run = 1; m_recall = 0;
            end
`ifdef STOPWATCH_LAP_RECALL_EN
            else if (l_w && n_laps() > 0) begin
                if (!m_recall) begin m_recall = 1; m_k = 0; end
                else m_k = m_k + 1;
                m_idx = ((m_total - 1) - (m_k % n_laps())) % D;
            end
`endif
        end else if (m_done) begin
            if (c_w) begin m_done = 0; m_clr = 1; end
        end
    endtask

    // drive one cycle of pulses, advance the model at the edge, leave inputs idle
    task automatic apply(input logic ss, input logic lp, input logic cl, input logic tk);
        start_stop = ss; lap = lp; clear = cl; tick = tk;
        time_bcd   = to_bcd(m_tenths);
        @(posedge clk);
        model_edge(ss, lp, cl, tk);
        #1;
        start_stop = 0; lap = 0; clear = 0; tick = 0;
        time_bcd   = to_bcd(m_tenths);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1;
        #1;
        model_reset();
        m_tenths = 0;
        time_bcd = 16'h0000;
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        model_reset();
        m_tenths = 0;
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL reset_state: got %h want %h", obs, exp_vec());
        end
        @(negedge clk);
        rst = 0;
        #1;
        apply(1, 0, 0, 0);
        m_tenths = 834;
        apply(0, 0, 0, 0);
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL run_before_reset: got %h want %h", obs, exp_vec());
        end
        #2;
        rst = 1;
        #1;
        model_reset();
        n_vec++;
        if ({cnt_en, busy, lap_active, lap_count} !== 6'b0 || disp_bcd !== 16'h1234) begin
            n_err++;
            $display("FAIL async_reset: got en=%b busy=%b cnt=%0d disp=%h want 0 0 0 1234",
                     cnt_en, busy, lap_count, disp_bcd);
        end
        @(negedge clk);
        rst = 0;
        m_tenths = 0;
        time_bcd = 16'h0000;
        #1;
    endtask

    task automatic test_lap_hold();
        int ticks;
        logic tk;
        do_reset();
        apply(1, 0, 0, 0);
        for (int i = 0; i < 35; i++) begin
            apply(0, 0, 0, 1);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL lap_run_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        apply(0, 1, 0, 0);
        n_vec++;
        if (disp_bcd !== 16'h0035 || lap_active !== 1'b1 || cnt_en !== 1'b1) begin
            n_err++;
            $display("FAIL lap_capture: got disp=%h act=%b en=%b want 0035 1 1", disp_bcd, lap_active, cnt_en);
        end
        n_vec++;
        if (dut.u_buf.mem[0] !== 16'h0035) begin
            n_err++; $display("FAIL lap_buf0: got %h want 0035", dut.u_buf.mem[0]);
        end
        ticks = 0;
        for (int i = 0; i < 200 && ticks < HOLD; i++) begin
            tk = 1'($urandom_range(0, 1));
            apply(0, 0, 0, tk);
            ticks += int'(tk);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL lap_hold_%0d: got %h want %h", ticks, obs, exp_vec());
            end
        end
        n_vec++;
        if (ticks != HOLD || lap_active !== 1'b0 || disp_bcd !== time_bcd || busy !== 1'b1) begin
            n_err++;
            $display("FAIL lap_release: got ticks=%0d act=%b disp=%h want %0d 0 %h",
                     ticks, lap_active, disp_bcd, HOLD, time_bcd);
        end
    endtask

    task automatic test_five_laps();
        int gap;
        do_reset();
        apply(1, 0, 0, 0);
        for (int l = 0; l < 5; l++) begin
            gap = $urandom_range(1, 6);
            for (int g = 0; g < gap; g++) apply(0, 0, 0, 1'($urandom_range(0, 1)));
            apply(0, 1, 0, 1'($urandom_range(0, 1)));
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL five_lap_%0d: got %h want %h", l, obs, exp_vec());
            end
        end
        n_vec++;
        if (lap_count !== 3'd4 || lap_idx !== 2'd0 || dut.u_buf.wr_ptr !== 2'd1) begin
            n_err++;
            $display("FAIL five_lap_ptrs: got cnt=%0d idx=%0d wr=%0d want 4 0 1",
                     lap_count, lap_idx, dut.u_buf.wr_ptr);
        end
        n_vec++;
        if (dut.u_buf.mem[0] !== m_latch || disp_bcd !== m_latch) begin
            n_err++;
            $display("FAIL five_lap_wrap: got buf0=%h disp=%h want %h", dut.u_buf.mem[0], disp_bcd, m_latch);
        end
    endtask

    task automatic test_max();
        do_reset();
        m_tenths = T_MAX - 9;
        apply(1, 0, 0, 0);
        for (int i = 0; i < 20 && m_tenths != T_MAX; i++) begin
            apply(0, 0, 0, 1);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL max_run_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
        n_vec++;
        if (time_bcd !== 16'h9599 || cnt_en !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL max_en_drop: got time=%h en=%b busy=%b want 9599 0 1", time_bcd, cnt_en, busy);
        end
        apply(0, 0, 0, 1);
        n_vec++;
        if (busy !== 1'b0 || cnt_en !== 1'b0 || disp_bcd !== 16'h9599 || obs !== exp_vec()) begin
            n_err++; $display("FAIL max_done: got %h want %h", obs, exp_vec());
        end
        apply(1, 0, 0, 0);
        n_vec++;
        if (busy !== 1'b0 || cnt_clr !== 1'b0) begin
            n_err++; $display("FAIL done_ignore_ss: got busy=%b clr=%b want 0 0", busy, cnt_clr);
        end
        apply(0, 0, 1, 0);
        n_vec++;
        if (cnt_clr !== 1'b1 || obs !== exp_vec()) begin
            n_err++; $display("FAIL done_clear: got %h want %h", obs, exp_vec());
        end
        apply(0, 0, 0, 0);
        n_vec++;
        if (cnt_clr !== 1'b0 || disp_bcd !== 16'h0000 || obs !== exp_vec()) begin
            n_err++; $display("FAIL clear_one_cycle: got %h want %h", obs, exp_vec());
        end
        apply(1, 0, 0, 0);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL idle_after_clear: got busy=%b want 1", busy);
        end
    endtask

    task automatic test_priority();
        do_reset();
        apply(1, 0, 0, 0);
        apply(0, 0, 1, 0);
        n_vec++;
        if (busy !== 1'b1 || cnt_clr !== 1'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL run_clear_ignored: got %h want %h", obs, exp_vec());
        end
        apply(0, 1, 1, 0);
        n_vec++;
        if (lap_active !== 1'b0 || lap_count !== 3'd0 || busy !== 1'b1) begin
            n_err++; $display("FAIL clear_drops_lap: got act=%b cnt=%0d want 0 0", lap_active, lap_count);
        end
        apply(1, 0, 0, 0);
        apply(1, 0, 1, 0);
        n_vec++;
        if (cnt_clr !== 1'b1 || busy !== 1'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL pause_clear_wins: got %h want %h", obs, exp_vec());
        end
        apply(0, 0, 0, 0);
        n_vec++;
        if (obs !== exp_vec()) begin
            n_err++; $display("FAIL pause_clear_idle: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_recall();
        int seq [4];
        seq = '{2, 1, 0, 2};
        do_reset();
        apply(1, 0, 0, 0);
        for (int l = 0; l < 3; l++) begin
            for (int g = 0; g < 3; g++) apply(0, 0, 0, 1);
            apply(0, 1, 0, 0);
        end
        apply(1, 0, 0, 0);
        for (int p = 0; p < 4; p++) begin
            apply(0, 1, 0, 0);
            n_vec++;
`ifdef STOPWATCH_LAP_RECALL_EN
            if (lap_idx !== 2'(seq[p]) || lap_active !== 1'b1 || disp_bcd !== m_mem[seq[p]]) begin
                n_err++;
                $display("FAIL recall_%0d: got idx=%0d act=%b disp=%h want %0d 1 %h",
                         p, lap_idx, lap_active, disp_bcd, seq[p], m_mem[seq[p]]);
            end
`else
            if (lap_idx !== 2'(seq[0]) || lap_active !== 1'b0 || disp_bcd !== time_bcd) begin
                n_err++;
                $display("FAIL no_recall_%0d: got idx=%0d act=%b disp=%h want 2 0 %h",
                         p, lap_idx, lap_active, disp_bcd, time_bcd);
            end
`endif
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL recall_vec_%0d: got %h want %h", p, obs, exp_vec());
            end
        end
        apply(1, 0, 0, 0);
        n_vec++;
        if (lap_active !== 1'b0 || disp_bcd !== time_bcd || obs !== exp_vec()) begin
            n_err++; $display("FAIL recall_exit: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_random();
        logic ss, lp, cl, tk;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (m_idle && $urandom_range(0, 3) == 0)
                m_tenths = (($urandom_range(0, 1) == 0) ? $urandom_range(T_MAX - 40, T_MAX)
                                                        : $urandom_range(0, 200));
            ss = 1'($urandom_range(0, 11) == 0);
            lp = 1'($urandom_range(0, 7) == 0);
            cl = 1'($urandom_range(0, 13) == 0);
            tk = 1'($urandom_range(0, 1));
            apply(ss, lp, cl, tk);
            n_vec++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL random_%0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        #3;
        test_reset();
        test_lap_hold();
        test_five_laps();
        test_max();
        test_priority();
        test_recall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
